// File: rtl/mopshub_irq_pkg.sv
// Shared constants and state encoding for the MOPSHUB per-bus event encoder.
package mopshub_irq_pkg;

    localparam int unsigned N_BUS_DEF  = 32;
    localparam int unsigned ID_W_DEF   = 5;
    localparam int unsigned MISS_CNT_W = 8;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } irq_state_e;

endpackage

// File: rtl/rr_priority_sel.sv
// Combinational round-robin search: first set request at or above start, wrapping to 0.
module rr_priority_sel #(
    parameter int unsigned N = 32,
    parameter int unsigned W = 5
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    output logic         found,
    output logic [W-1:0] index
);

    logic [W-1:0] cand;

    always_comb begin
        found = 1'b0;
        index = '0;
        cand  = '0;
        for (int i = 0; i < N; i++) begin
            // W-bit addition wraps naturally at N-1 because N is a power of two.
            cand = start + W'(i);
            if (!found && req[cand]) begin
                found = 1'b1;
                index = cand;
            end
        end
    end

endmodule

// File: rtl/node_irq_encoder.sv
// Latches per-bus event edges and presents them one at a time with round-robin fairness.
// Optional merged-edge counter enabled by defining NODE_IRQ_MISS_CNT_EN.
module node_irq_encoder
    import mopshub_irq_pkg::*;
#(
    parameter int unsigned N_BUS = N_BUS_DEF,
    parameter int unsigned ID_W  = ID_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_BUS-1:0]      irq_in,
    output logic                  irq_valid_o,
    output logic [ID_W-1:0]       irq_id_o,
    input  logic                  irq_ack_i,
    output logic [N_BUS-1:0]      pending_o,
`ifdef NODE_IRQ_MISS_CNT_EN
    input  logic                  miss_clr_i,
    output logic [MISS_CNT_W-1:0] miss_cnt_o,
`endif
    output logic                  busy_o
);

    irq_state_e       state_q, state_d;
    logic [N_BUS-1:0] irq_in_q, pending_q, pending_d, edges, clr_mask;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d, id_q, id_d, sel_idx;
    logic             valid_q, valid_d, busy_q, busy_d, sel_found;

    assign edges = irq_in & ~irq_in_q;

    rr_priority_sel #(
        .N (N_BUS),
        .W (ID_W)
    ) u_sel (
        .req   (pending_q),
        .start (rr_ptr_q),
        .found (sel_found),
        .index (sel_idx)
    );

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        id_d     = id_q;
        valid_d  = valid_q;
        clr_mask = '0;
        unique case (state_q)
            IDLE: begin
                if (sel_found) begin
                    id_d    = sel_idx;
                    valid_d = 1'b1;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (irq_ack_i) begin
                    clr_mask[id_q] = 1'b1;
                    rr_ptr_d       = id_q + ID_W'(1);
                    valid_d        = 1'b0;
                    state_d        = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A new edge in the ack cycle overrides the clear so the event is not lost.
        pending_d = (pending_q & ~clr_mask) | edges;
        busy_d    = (|pending_d) | valid_d;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            irq_in_q  <= '0;
            pending_q <= '0;
            rr_ptr_q  <= '0;
            id_q      <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            irq_in_q  <= irq_in;
            pending_q <= pending_d;
            rr_ptr_q  <= rr_ptr_d;
            id_q      <= id_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
        end
    end

    assign irq_valid_o = valid_q;
    assign irq_id_o    = id_q;
    assign pending_o   = pending_q;
    assign busy_o      = busy_q;

`ifdef NODE_IRQ_MISS_CNT_EN
    logic [MISS_CNT_W-1:0] miss_cnt_q, miss_cnt_d;
    logic                  merged;

    // Edges that re-arm a bit being cleared this cycle start a fresh event, so they are not misses.
    assign merged = |(edges & pending_q & ~clr_mask);

    always_comb begin
        miss_cnt_d = miss_cnt_q;
        if (miss_clr_i) begin
            miss_cnt_d = '0;
        end else if (merged && (miss_cnt_q != '1)) begin
            miss_cnt_d = miss_cnt_q + MISS_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            miss_cnt_q <= '0;
        end else begin
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_node_irq_encoder.sv
// Directed self-checking bench for node_irq_encoder.
module tb_node_irq_encoder;
    import mopshub_irq_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] irq_in;
    logic        irq_valid_o;
    logic [4:0]  irq_id_o;
    logic        irq_ack_i;
    logic [31:0] pending_o;
    logic        busy_o;
`ifdef NODE_IRQ_MISS_CNT_EN
    logic        miss_clr_i;
    logic [7:0]  miss_cnt_o;
`endif

    int errors = 0;
    int checks = 0;

    node_irq_encoder dut (
        .clk         (clk),
        .rst         (rst),
        .irq_in      (irq_in),
        .irq_valid_o (irq_valid_o),
        .irq_id_o    (irq_id_o),
        .irq_ack_i   (irq_ack_i),
        .pending_o   (pending_o),
`ifdef NODE_IRQ_MISS_CNT_EN
        .miss_clr_i  (miss_clr_i),
        .miss_cnt_o  (miss_cnt_o),
`endif
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for a presented event, check its id, then ack it for one cycle.
    task automatic expect_event(input string tag, input logic [4:0] exp_id);
        int n = 0;
        while (!irq_valid_o && n < 10) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, {31'b0, irq_valid_o}, 32'd1);
        check(tag, {27'b0, irq_id_o}, {27'b0, exp_id});
        irq_ack_i = 1'b1;
        tick();
        irq_ack_i = 1'b0;
        check({tag, "_drop"}, {31'b0, irq_valid_o}, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    initial begin
        int n_ev;
        logic [4:0] seen_id;

        rst       = 1'b0;
        irq_in    = '0;
        irq_ack_i = 1'b0;
`ifdef NODE_IRQ_MISS_CNT_EN
        miss_clr_i = 1'b0;
`endif
        tick();
        tick();
        rst = 1'b1;
        check("rst_valid", {31'b0, irq_valid_o}, 32'd0);
        check("rst_id", {27'b0, irq_id_o}, 32'd0);
        check("rst_pending", pending_o, 32'd0);
        check("rst_busy", {31'b0, busy_o}, 32'd0);

        // Single event on bus 3: pending after one edge, presented after two.
        irq_in[3] = 1'b1;
        tick();
        check("single_pend", pending_o, 32'h8);
        check("single_valid_early", {31'b0, irq_valid_o}, 32'd0);
        check("single_busy", {31'b0, busy_o}, 32'd1);
        irq_in[3] = 1'b0;
        tick();
        check("single_valid", {31'b0, irq_valid_o}, 32'd1);
        check("single_id", {27'b0, irq_id_o}, 32'd3);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_valid", {31'b0, irq_valid_o}, 32'd1);
            check("hold_id", {27'b0, irq_id_o}, 32'd3);
        end
        irq_ack_i = 1'b1;
        tick();
        irq_ack_i = 1'b0;
        check("ack_pending", pending_o, 32'd0);
        check("ack_valid", {31'b0, irq_valid_o}, 32'd0);
        check("ack_busy", {31'b0, busy_o}, 32'd0);

        // Held level on bus 10 yields exactly one event.
        irq_in[10] = 1'b1;
        n_ev       = 0;
        seen_id    = '0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (irq_valid_o) begin
                n_ev++;
                seen_id   = irq_id_o;
                irq_ack_i = 1'b1;
            end else begin
                irq_ack_i = 1'b0;
            end
        end
        irq_ack_i = 1'b0;
        irq_in    = '0;
        check("level_count", n_ev, 32'd1);
        check("level_id", {27'b0, seen_id}, 32'd10);
        tick();

        // Reset in the middle of presenting id 7.
        irq_in[7] = 1'b1;
        tick();
        irq_in[7] = 1'b0;
        tick();
        check("mid_id", {27'b0, irq_id_o}, 32'd7);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("midrst_valid", {31'b0, irq_valid_o}, 32'd0);
        check("midrst_id", {27'b0, irq_id_o}, 32'd0);
        check("midrst_pending", pending_o, 32'd0);
        check("midrst_busy", {31'b0, busy_o}, 32'd0);

        // Round robin from pointer 0, wrap after 31, then pointer 6.
        irq_in = 32'h8000_0021;
        tick();
        irq_in = '0;
        expect_event("rr_a0", 5'd0);
        expect_event("rr_a5", 5'd5);
        expect_event("rr_a31", 5'd31);
        irq_in = 32'h0000_0021;
        tick();
        irq_in = '0;
        expect_event("rr_b0", 5'd0);
        expect_event("rr_b5", 5'd5);
        irq_in = 32'h0000_0204;
        tick();
        irq_in = '0;
        expect_event("rr_c9", 5'd9);
        expect_event("rr_c2", 5'd2);

        // Set/clear collision on bus 4 while bus 6 is also pending.
        do_reset();
        irq_in = 32'h0000_0050;
        tick();
        irq_in = '0;
        tick();
        check("coll_id", {27'b0, irq_id_o}, 32'd4);
        irq_in[4] = 1'b1;
        irq_ack_i = 1'b1;
        tick();
        irq_ack_i = 1'b0;
        irq_in    = '0;
        check("coll_pending", pending_o, 32'h50);
        check("coll_valid", {31'b0, irq_valid_o}, 32'd0);
        expect_event("coll_6", 5'd6);
        expect_event("coll_4", 5'd4);
        check("coll_empty", pending_o, 32'd0);

`ifdef NODE_IRQ_MISS_CNT_EN
        do_reset();
        check("miss_rst", {24'b0, miss_cnt_o}, 32'd0);
        irq_in[1] = 1'b1;
        tick();
        for (int i = 0; i < 300; i++) begin
            irq_in[1] = 1'b0;
            tick();
            irq_in[1] = 1'b1;
            tick();
            if (i == 2) check("miss_three", {24'b0, miss_cnt_o}, 32'd3);
        end
        check("miss_sat", {24'b0, miss_cnt_o}, 32'd255);
        irq_in[1] = 1'b0;
        tick();
        irq_in[1]  = 1'b1;
        miss_clr_i = 1'b1;
        tick();
        miss_clr_i = 1'b0;
        check("miss_clr", {24'b0, miss_cnt_o}, 32'd0);
        irq_in[1] = 1'b0;
        tick();
        irq_in[1] = 1'b1;
        tick();
        check("miss_after_clr", {24'b0, miss_cnt_o}, 32'd1);
        irq_in = '0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
